dcache_responder: RTL and testbench

Responder end of the LSQ-to-D-Cache request interface: it accepts single-word load/store requests from the LSQ, serves load hits from a direct-mapped store in one cycle, fills misses and writes stores through to backing memory over a req/ack handshake, and raises a stall that the core uses as `freeze_back`. It sits between the LSQ and the data-memory port.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_array.sv | 53 +++++
 rtl/dcache_responder.sv | 164 ++++++++++++++++
 tb/tb_dcache_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped D-cache responder.
// Tags are stored zero-extended to the widest possible tag (LINES=2) so one line struct fits every size.
package dcache_pkg;

  localparam int DEFAULT_LINES = 16;
  localparam int MAX_TAG_W     = 29;

  function automatic int idxW(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tagW(input int lines);
    return 30 - $clog2(lines);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          data;
  } line_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read by index, byte-enabled data write,
// separate tag/valid write and a global valid clear that overrides any same-edge write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = DEFAULT_LINES,
  localparam int IDX_W = idxW(LINES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     i_idx,
  output line_t                o_line,
  input  logic [3:0]           i_byte_we,
  input  logic [31:0]          i_wdata,
  input  logic                 i_tag_we,
  input  logic [MAX_TAG_W-1:0] i_tag,
  input  logic                 i_valid,
  input  logic                 i_clr_all
);

  logic [LINES-1:0]     r_valid;
  logic [MAX_TAG_W-1:0] r_tag  [LINES];
  logic [31:0]          r_data [LINES];

  always_comb begin
    o_line.valid = r_valid[i_idx];
    o_line.tag   = r_tag[i_idx];
    o_line.data  = r_data[i_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_idx] <= i_valid;
    end
  end

  // Tag and data need no reset: a line is only ever trusted through its valid bit.
  always_ff @(posedge clk) begin
    if (i_tag_we) begin
      r_tag[i_idx] <= i_tag;
    end
    for (int b = 0; b < 4; b++) begin
      if (i_byte_we[b]) begin
        r_data[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// LSQ-facing D-cache responder: one-cycle load hits, blocking miss fills and
// write-through stores over a registered req/ack memory port.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int LINES = DEFAULT_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dc_read_req,
  input  logic        dc_write_req,
  input  logic [29:0] dc_addr,
  input  logic [3:0]  dc_byte_w_en,
  input  logic [31:0] dc_wdata,
  output logic [31:0] dc_rdata,
  output logic        dc_rvalid,
  output logic        dc_stall,
  input  logic        dc_inv_all,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int IDX_W = idxW(LINES);
  localparam int TAG_W = tagW(LINES);

  state_t r_state, w_next;

  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [29:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;

  line_t                w_line;
  logic [29:0]          w_lookup_addr;
  logic [IDX_W-1:0]     w_idx;
  logic [MAX_TAG_W-1:0] w_tag;
  logic                 w_hit;
  logic                 w_do_write;
  logic                 w_do_read;
  logic [3:0]           w_byte_we;
  logic [31:0]          w_arr_wdata;
  logic                 w_tag_we;

  // While a fill is outstanding the array is addressed by the latched request.
  assign w_lookup_addr = (r_state == IDLE) ? dc_addr : r_mem_addr;
  assign w_idx         = w_lookup_addr[IDX_W-1:0];
  assign w_tag         = MAX_TAG_W'(w_lookup_addr[29 -: TAG_W]);
  assign w_hit         = w_line.valid && (w_line.tag == w_tag);
  assign w_do_write    = (r_state == IDLE) && dc_write_req && (dc_byte_w_en != 4'b0000);
  assign w_do_read     = (r_state == IDLE) && dc_read_req && !dc_write_req;

  always_comb begin
    w_byte_we   = 4'b0000;
    w_arr_wdata = dc_wdata;
    w_tag_we    = 1'b0;
    if (w_do_write && w_hit) begin
      w_byte_we = dc_byte_w_en;
    end else if (r_state == FILL && mem_ack) begin
      w_byte_we   = 4'b1111;
      w_arr_wdata = mem_rdata;
      w_tag_we    = 1'b1;
    end
  end

  dcache_array #(.LINES(LINES)) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (w_idx),
    .o_line    (w_line),
    .i_byte_we (w_byte_we),
    .i_wdata   (w_arr_wdata),
    .i_tag_we  (w_tag_we),
    .i_tag     (w_tag),
    .i_valid   (1'b1),
    .i_clr_all (dc_inv_all)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_do_write)               w_next = WRITE;
        else if (w_do_read && !w_hit) w_next = FILL;
      end
      FILL:    if (mem_ack) w_next = IDLE;
      WRITE:   if (mem_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Memory-side outputs are registered and only reloaded from IDLE, so they hold until the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_rvalid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_do_write) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= dc_addr;
            r_mem_be    <= dc_byte_w_en;
            r_mem_wdata <= dc_wdata;
          end else if (w_do_read) begin
            if (w_hit) begin
              r_rdata  <= w_line.data;
              r_rvalid <= 1'b1;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= dc_addr;
              r_mem_be   <= 4'b1111;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            r_rdata   <= mem_rdata;
            r_rvalid  <= 1'b1;
            r_mem_req <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_ack) r_mem_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dc_rdata  = r_rdata;
  assign dc_rvalid = r_rvalid;
  assign dc_stall  = (r_state != IDLE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

  // The LSQ never issues a load and a store together; the store would win.
  a_no_dual_req: assert property (@(posedge clk) disable iff (rst)
    !(dc_read_req && dc_write_req && !dc_stall));

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: a word-level memory model plus a
// reference map of which addresses are resident decides hits, misses and data.
module tb_dcache_responder;

  localparam int LINES = 16;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } memTxn_t;

  logic        clk;
  logic        rst;
  logic        dc_read_req;
  logic        dc_write_req;
  logic [29:0] dc_addr;
  logic [3:0]  dc_byte_w_en;
  logic [31:0] dc_wdata;
  logic [31:0] dc_rdata;
  logic        dc_rvalid;
  logic        dc_stall;
  logic        dc_inv_all;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  dcache_responder #(.LINES(LINES)) dut (
    .clk          (clk),
    .rst          (rst),
    .dc_read_req  (dc_read_req),
    .dc_write_req (dc_write_req),
    .dc_addr      (dc_addr),
    .dc_byte_w_en (dc_byte_w_en),
    .dc_wdata     (dc_wdata),
    .dc_rdata     (dc_rdata),
    .dc_rvalid    (dc_rvalid),
    .dc_stall     (dc_stall),
    .dc_inv_all   (dc_inv_all),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Backing memory contents, the set of resident addresses, and pending expectations.
  logic [31:0] memArr [logic [29:0]];
  bit          refValid [LINES];
  logic [29:0] refTag [LINES];
  logic [31:0] rdataQ [$];
  memTxn_t     memQ [$];

  int      ackDelay = 0;
  bit      invOnAck = 0;
  bit      invPulseReq = 0;
  bit      forceLateAck = 0;
  int      waitCnt = 0;
  bit      active = 0;
  memTxn_t curTxn;
  logic    monPrev = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [29:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Load monitor: every rvalid pulse must match the oldest expected load result.
  initial begin
    forever begin
      @(negedge clk);
      if (dc_rvalid === 1'b1) begin
        checkOutput("rvalidPulse", monPrev, 1'b0);
        if (rdataQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpectedRvalid: got rdata 0x%0h, expected no response", dc_rdata);
        end else begin
          checkOutput("loadData", dc_rdata, rdataQ.pop_front());
        end
      end
      monPrev = dc_rvalid;
    end
  end

  // Memory responder: checks each request against the expected transaction and acks after ackDelay extra cycles.
  initial begin
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    dc_inv_all = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack    = 1'b0;
      dc_inv_all = 1'b0;
      if (invPulseReq) begin
        dc_inv_all  = 1'b1;
        invPulseReq = 0;
      end
      if (rst) begin
        active  = 0;
        waitCnt = 0;
      end else if (forceLateAck) begin
        mem_ack      = 1'b1;
        mem_rdata    = 32'hBAD0_BAD0;
        forceLateAck = 0;
      end else if (mem_req === 1'b1) begin
        if (!active) begin
          active  = 1;
          waitCnt = 0;
          if (memQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpectedMemReq: got we=%0b addr=0x%0h, expected no access", mem_we, mem_addr);
            curTxn.we = mem_we; curTxn.addr = mem_addr; curTxn.be = mem_be; curTxn.wdata = mem_wdata;
          end else begin
            curTxn = memQ.pop_front();
            checkOutput("memWe", mem_we, curTxn.we);
            checkOutput("memAddr", mem_addr, curTxn.addr);
            checkOutput("memBe", mem_be, curTxn.be);
            if (curTxn.we) checkOutput("memWdata", mem_wdata, curTxn.wdata);
          end
        end
        if (waitCnt >= ackDelay) begin
          checkOutput("memAddrHeld", mem_addr, curTxn.addr);
          checkOutput("memBeHeld", mem_be, curTxn.be);
          mem_ack = 1'b1;
          if (curTxn.we) begin
            logic [31:0] w;
            w = memRead(curTxn.addr);
            for (int b = 0; b < 4; b++)
              if (curTxn.be[b]) w[8*b +: 8] = curTxn.wdata[8*b +: 8];
            memArr[curTxn.addr] = w;
          end else begin
            mem_rdata = memRead(curTxn.addr);
          end
          if (invOnAck) begin
            dc_inv_all = 1'b1;
            invOnAck   = 0;
          end
          active = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        active  = 0;
        waitCnt = 0;
      end
    end
  end

  task automatic applyStimulus(input bit rd, input bit wr, input logic [29:0] a, input logic [3:0] be,
                               input logic [31:0] d, input int expStall);
    int cnt;
    @(negedge clk);
    dc_read_req  = rd;
    dc_write_req = wr;
    dc_addr      = a;
    dc_byte_w_en = be;
    dc_wdata     = d;
    @(negedge clk);
    dc_read_req  = 1'b0;
    dc_write_req = 1'b0;
    cnt = 0;
    while (dc_stall === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("stallCycles", cnt, expStall);
    @(negedge clk);
  endtask

  task automatic doRead(input logic [29:0] a, input int delay, input bit invAtAck);
    int      idx;
    bit      hit;
    int      expStall;
    memTxn_t t;
    idx = int'(a % LINES);
    hit = refValid[idx] && (refTag[idx] == a);
    rdataQ.push_back(memRead(a));
    expStall = 0;
    if (!hit) begin
      ackDelay = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
      t.we = 1'b0; t.addr = a; t.be = 4'b1111; t.wdata = '0;
      memQ.push_back(t);
      expStall = ackDelay + 1;
      invOnAck = invAtAck;
    end
    applyStimulus(1'b1, 1'b0, a, 4'b0000, 32'h0, expStall);
    if (!hit) begin
      if (invAtAck) begin
        for (int i = 0; i < LINES; i++) refValid[i] = 0;
      end else begin
        refValid[idx] = 1;
        refTag[idx]   = a;
      end
    end
  endtask

  task automatic doWrite(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    int      expStall;
    memTxn_t t;
    expStall = 0;
    if (be != 4'b0000) begin
      ackDelay = int'($urandom_range(0, 3));
      t.we = 1'b1; t.addr = a; t.be = be; t.wdata = d;
      memQ.push_back(t);
      expStall = ackDelay + 1;
    end
    applyStimulus(1'b0, 1'b1, a, be, d, expStall);
  endtask

  task automatic pulseInv();
    invPulseReq = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < LINES; i++) refValid[i] = 0;
  endtask

  initial begin
    memTxn_t t;
    int      cnt;
    dc_read_req  = 1'b0;
    dc_write_req = 1'b0;
    dc_addr      = '0;
    dc_byte_w_en = '0;
    dc_wdata     = '0;
    for (int i = 0; i < LINES; i++) begin
      refValid[i] = 0;
      refTag[i]   = '0;
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstRdata", dc_rdata, 32'h0);
    checkOutput("rstRvalid", dc_rvalid, 1'b0);
    checkOutput("rstStall", dc_stall, 1'b0);
    checkOutput("rstMemReq", mem_req, 1'b0);
    checkOutput("rstMemWe", mem_we, 1'b0);
    checkOutput("rstMemAddr", mem_addr, 30'h0);
    checkOutput("rstMemBe", mem_be, 4'h0);
    checkOutput("rstMemWdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Miss fill with a three-cycle stall, then a hit, a partial store hit and a merged re-read.
    memArr[30'h10] = 32'hDEAD_BEEF;
    doRead(30'h10, 2, 0);
    doRead(30'h10, -1, 0);
    doWrite(30'h10, 4'b0011, 32'h1234_5678);
    doRead(30'h10, -1, 0);

    // Store miss does not allocate; same-index conflict evicts; zero-enable store is a no-op.
    doWrite(30'h20, 4'b1111, 32'hCAFE_F00D);
    doRead(30'h20, -1, 0);
    doRead(30'h05, -1, 0);
    doRead(30'h15, -1, 0);
    doRead(30'h05, -1, 0);
    doWrite(30'h05, 4'b0000, 32'hFFFF_FFFF);
    doRead(30'h05, -1, 0);

    // Invalidate coinciding with a fill ack: data returned, line left invalid.
    doRead(30'h07, 1, 1);
    doRead(30'h07, -1, 0);

    // Reset in the middle of a fill abandons it and ignores a late ack.
    pulseInv();
    ackDelay = 20;
    t.we = 1'b0; t.addr = 30'h33; t.be = 4'b1111; t.wdata = '0;
    memQ.push_back(t);
    @(negedge clk);
    dc_read_req = 1'b1;
    dc_addr     = 30'h33;
    @(negedge clk);
    dc_read_req = 1'b0;
    cnt = 0;
    while (mem_req !== 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("fillStarted", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("memReqOnReset", mem_req, 1'b0);
    checkOutput("stallOnReset", dc_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LINES; i++) refValid[i] = 0;
    forceLateAck = 1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("lateAckMemReq", mem_req, 1'b0);
      checkOutput("lateAckStall", dc_stall, 1'b0);
    end
    doRead(30'h33, -1, 0);

    // Random mix over a small address pool so hits, conflicts and invalidations recur.
    for (int n = 0; n < 120; n++) begin
      int          r;
      logic [29:0] a;
      r = int'($urandom_range(0, 99));
      a = 30'($urandom_range(0, 47));
      if (r < 50)      doRead(a, -1, ($urandom_range(0, 9) == 0));
      else if (r < 92) doWrite(a, 4'($urandom_range(0, 15)), $urandom);
      else             pulseInv();
    end

    repeat (4) @(negedge clk);
    checkOutput("rdataQEmpty", rdataQ.size(), 0);
    checkOutput("memQEmpty", memQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
